// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port synchronous word RAM between three requesters:
// the MEM-stage data port (read/write), the IF-stage fetch port (read) and
// the UI debug port (read). Fixed priority data > fetch > debug, except that
// a debug request that has lost STARVE_LIMIT arbitrations in a row wins
// outright. Each access runs IDLE -> ISSUE -> (WAIT) -> DONE, and the
// requester's ack pulses for one cycle after DONE.
//
// Ports
//   clock, reset                 system clock, asynchronous active-low reset
//   d_req/d_we/d_addr/d_wdata    data request (byte address), write qualifier
//   d_ack                        one-cycle data completion pulse
//   i_req/i_addr, i_ack          fetch read request and completion pulse
//   g_req/g_addr, g_ack          debug read request and completion pulse
//   rdata                        read data, valid while any ack is high
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata          RAM interface (word address)
//   busy                         FSM not in IDLE
//   stall_if, stall_mem          pipeline stalls while fetch/data outstanding

module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    input  logic              g_req,
    input  logic [ADDR_W-1:0] g_addr,
    output logic              g_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int WAIT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WADDR_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_D = 2'd0,
        SRC_I = 2'd1,
        SRC_G = 2'd2
    } src_t;

    state_t              state;
    state_t              next_state;
    src_t                win_src;
    src_t                grant_src;
    logic                grant_valid;
    logic [WADDR_W-1:0]  grant_addr;
    logic [WADDR_W-1:0]  lat_addr;
    logic                lat_we;
    logic [DATA_W-1:0]   lat_wdata;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                ack_any;
    logic                arb_en;
    logic                g_starved;
    logic                unused_addr_lsbs;

    // Byte-lane bits are irrelevant to a word RAM.
    assign unused_addr_lsbs = ^{d_addr[1:0], i_addr[1:0], g_addr[1:0]};

    // Acks are registered, so during the ack cycle the FSM is already back in
    // IDLE while the finished requester still holds its req. Arbitration is
    // held off for that cycle so the same request is not granted twice.
    assign ack_any   = d_ack | i_ack | g_ack;
    assign arb_en    = (state == IDLE) && !ack_any;
    assign g_starved = g_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Winner selection: starving debug first, then data > fetch > debug.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_D;
        grant_addr  = d_addr[ADDR_W-1:2];
        if (arb_en) begin
            if (g_starved) begin
                grant_valid = 1'b1;
                grant_src   = SRC_G;
                grant_addr  = g_addr[ADDR_W-1:2];
            end else if (d_req) begin
                grant_valid = 1'b1;
                grant_src   = SRC_D;
                grant_addr  = d_addr[ADDR_W-1:2];
            end else if (i_req) begin
                grant_valid = 1'b1;
                grant_src   = SRC_I;
                grant_addr  = i_addr[ADDR_W-1:2];
            end else if (g_req) begin
                grant_valid = 1'b1;
                grant_src   = SRC_G;
                grant_addr  = g_addr[ADDR_W-1:2];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: writes skip WAIT since nothing comes back from the RAM.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = grant_valid ? ISSUE : IDLE;
            ISSUE:   next_state = lat_we ? DONE : WAIT;
            WAIT:    next_state = (wait_cnt == '0) ? DONE : WAIT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: the RAM is only touched during ISSUE.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        busy      = (state != IDLE);
        stall_if  = i_req & ~i_ack;
        stall_mem = d_req & ~d_ack;
        if (state == ISSUE) begin
            mem_en = 1'b1;
            mem_we = lat_we;
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // Request latches, read-latency counter, read capture and acks. The
    // latched winner drives the transaction to completion even if its req is
    // dropped early.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_src   <= SRC_D;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            rdata     <= '0;
            d_ack     <= 1'b0;
            i_ack     <= 1'b0;
            g_ack     <= 1'b0;
        end else begin
            if (grant_valid) begin
                win_src   <= grant_src;
                lat_addr  <= grant_addr;
                lat_we    <= (grant_src == SRC_D) && d_we;
                lat_wdata <= (grant_src == SRC_D) ? d_wdata : '0;
            end
            if (state == ISSUE && !lat_we) begin
                wait_cnt <= WAIT_W'(RD_LAT - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (state == WAIT && wait_cnt == '0) begin
                rdata <= mem_rdata;
            end
            d_ack <= (state == DONE) && (win_src == SRC_D);
            i_ack <= (state == DONE) && (win_src == SRC_I);
            g_ack <= (state == DONE) && (win_src == SRC_G);
        end
    end

    // Debug starvation counter: counts real arbitrations debug lost, and is
    // cleared as soon as debug is granted or stops asking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!g_req) begin
                starve_cnt <= '0;
            end else if (grant_valid) begin
                if (grant_src == SRC_G) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances: one with the default
// read latency and one built with RD_LAT=3, each attached to a small
// behavioural synchronous RAM whose read data is only valid exactly RD_LAT
// edges after the issue edge (a marker value otherwise).
//
// Ports: none (top-level bench).

module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic clock;
    logic reset;

    logic              d_req, d_we, d_ack, i_req, i_ack, g_req, g_ack;
    logic [ADDR_W-1:0] d_addr, i_addr, g_addr;
    logic [DATA_W-1:0] d_wdata, rdata, mem_wdata, mem_rdata;
    logic              mem_en, mem_we, busy, stall_if, stall_mem;
    logic [ADDR_W-3:0] mem_addr;

    logic              s_d_req, s_d_we, s_d_ack, s_i_req, s_i_ack, s_g_req, s_g_ack;
    logic [ADDR_W-1:0] s_d_addr, s_i_addr, s_g_addr;
    logic [DATA_W-1:0] s_d_wdata, s_rdata, s_mem_wdata, s_mem_rdata;
    logic              s_mem_en, s_mem_we, s_busy, s_stall_if, s_stall_mem;
    logic [ADDR_W-3:0] s_mem_addr;

    logic              ld_en;
    logic [ADDR_W-3:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    int n_asserts;
    int n_fail;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .g_req(g_req), .g_addr(g_addr), .g_ack(g_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .STARVE_LIMIT(8)) dut_lat3 (
        .clock(clock), .reset(reset),
        .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr), .d_wdata(s_d_wdata), .d_ack(s_d_ack),
        .i_req(s_i_req), .i_addr(s_i_addr), .i_ack(s_i_ack),
        .g_req(s_g_req), .g_addr(s_g_addr), .g_ack(s_g_ack),
        .rdata(s_rdata), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata),
        .busy(s_busy), .stall_if(s_stall_if), .stall_mem(s_stall_mem)
    );

    // RAM for the RD_LAT=1 instance: read data valid for one cycle after the
    // edge that samples the read.
    logic [DATA_W-1:0] ram1 [0:16383];
    logic              rd1_vld;
    logic [DATA_W-1:0] rd1_data;

    always @(posedge clock) begin
        if (ld_en) ram1[ld_addr] <= ld_data;
        else if (mem_en && mem_we) ram1[mem_addr] <= mem_wdata;
        rd1_vld  <= mem_en && !mem_we;
        rd1_data <= ram1[mem_addr];
    end
    assign mem_rdata = rd1_vld ? rd1_data : 32'hBAD0_BAD0;

    // RAM for the RD_LAT=3 instance: three-stage read pipeline.
    logic [DATA_W-1:0] ram3 [0:16383];
    logic [2:0]        rd3_vld;
    logic [DATA_W-1:0] rd3_data [0:2];

    always @(posedge clock) begin
        if (ld_en) ram3[ld_addr] <= ld_data;
        else if (s_mem_en && s_mem_we) ram3[s_mem_addr] <= s_mem_wdata;
        rd3_vld     <= {rd3_vld[1:0], s_mem_en && !s_mem_we};
        rd3_data[0] <= ram3[s_mem_addr];
        rd3_data[1] <= rd3_data[0];
        rd3_data[2] <= rd3_data[1];
    end
    assign s_mem_rdata = rd3_vld[2] ? rd3_data[2] : 32'hBAD0_BAD0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dr, input logic dw, input logic [15:0] da,
                                 input logic [31:0] dd, input logic ir, input logic [15:0] ia,
                                 input logic gr, input logic [15:0] ga);
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        i_req = ir; i_addr = ia; g_req = gr; g_addr = ga;
        #1;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] v);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         dcnt;
        int         icnt;
        int         gcyc;
        logic [2:0] first;
        logic [2:0] exp_acks;

        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        s_d_req = 0; s_d_we = 0; s_d_addr = '0; s_d_wdata = '0;
        s_i_req = 0; s_i_addr = '0; s_g_req = 0; s_g_addr = '0;
        applyStimulus(0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 16'h0);

        // Reset state
        @(negedge clock);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_acks", {d_ack, i_ack, g_ack}, 0);
        checkOutput("rst_mem_en_we", {mem_en, mem_we}, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b1;
        preload(14'd4, 32'hDEAD_BEEF);
        preload(14'd6, 32'h600D_F00D);

        // Single fetch
        $display("[TB] single fetch");
        @(negedge clock);
        applyStimulus(0, 0, 16'h0, 32'h0, 1, 16'h0010, 0, 16'h0);
        checkOutput("fetch_c0_stall", stall_if, 1);
        checkOutput("fetch_c0_en", mem_en, 0);
        @(negedge clock);
        checkOutput("fetch_c1_en_we", {mem_en, mem_we}, 2'b10);
        checkOutput("fetch_c1_addr", mem_addr, 14'h0004);
        checkOutput("fetch_c1_busy", busy, 1);
        @(negedge clock);
        checkOutput("fetch_c2_en", mem_en, 0);
        checkOutput("fetch_c2_stall", stall_if, 1);
        @(negedge clock);
        checkOutput("fetch_c3_acks", {d_ack, i_ack, g_ack}, 0);
        checkOutput("fetch_c3_stall", stall_if, 1);
        @(negedge clock);
        checkOutput("fetch_c4_acks", {d_ack, i_ack, g_ack}, 3'b010);
        checkOutput("fetch_c4_rdata", rdata, 32'hDEAD_BEEF);
        checkOutput("fetch_c4_stall", stall_if, 0);
        applyStimulus(0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 16'h0);
        @(negedge clock);
        checkOutput("fetch_c5_idle", {busy, d_ack, i_ack, g_ack}, 0);

        // Data write
        $display("[TB] data write");
        @(negedge clock);
        applyStimulus(1, 1, 16'h0008, 32'h1234_5678, 0, 16'h0, 0, 16'h0);
        checkOutput("wr_c0_stall", stall_mem, 1);
        @(negedge clock);
        checkOutput("wr_c1_en_we", {mem_en, mem_we}, 2'b11);
        checkOutput("wr_c1_addr", mem_addr, 14'h0002);
        checkOutput("wr_c1_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clock);
        checkOutput("wr_c2_acks_en", {d_ack, i_ack, g_ack, mem_en, mem_we}, 0);
        @(negedge clock);
        checkOutput("wr_c3_acks", {d_ack, i_ack, g_ack}, 3'b100);
        checkOutput("wr_c3_rdata", rdata, 32'hDEAD_BEEF);
        checkOutput("wr_c3_stall", stall_mem, 0);
        applyStimulus(0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 16'h0);
        @(negedge clock);
        checkOutput("wr_ram", ram1[2], 32'h1234_5678);

        // Write whose req is dropped right after the grant still completes
        $display("[TB] early req drop");
        @(negedge clock);
        applyStimulus(1, 1, 16'h0014, 32'h0BAD_C0DE, 0, 16'h0, 0, 16'h0);
        @(negedge clock);
        applyStimulus(0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 16'h0);
        checkOutput("drop_c1_en_we", {mem_en, mem_we}, 2'b11);
        checkOutput("drop_c1_addr", mem_addr, 14'h0005);
        @(negedge clock);
        @(negedge clock);
        checkOutput("drop_c3_acks", {d_ack, i_ack, g_ack}, 3'b100);
        @(negedge clock);
        checkOutput("drop_ram", ram1[5], 32'h0BAD_C0DE);

        // Three-way contention
        $display("[TB] contention");
        @(negedge clock);
        applyStimulus(1, 1, 16'h000C, 32'hCAFE_F00D, 1, 16'h0008, 1, 16'h0010);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clock);
            exp_acks = (c == 3) ? 3'b100 : (c == 8) ? 3'b010 : (c == 13) ? 3'b001 : 3'b000;
            checkOutput($sformatf("cont_acks_c%0d", c), {d_ack, i_ack, g_ack}, exp_acks);
            if (c == 3) d_req = 1'b0;
            if (c == 8) begin
                checkOutput("cont_i_rdata", rdata, 32'h1234_5678);
                i_req = 1'b0;
            end
            if (c == 13) begin
                checkOutput("cont_g_rdata", rdata, 32'hDEAD_BEEF);
                g_req = 1'b0;
            end
        end
        @(negedge clock);
        checkOutput("cont_ram", ram1[3], 32'hCAFE_F00D);

        // Debug starvation guard
        $display("[TB] starvation");
        @(negedge clock);
        applyStimulus(1, 1, 16'h0020, 32'h55AA_55AA, 1, 16'h0000, 1, 16'h0010);
        dcnt = 0;
        icnt = 0;
        gcyc = -1;
        for (int c = 0; c < 60 && gcyc < 0; c++) begin
            if (c > 0) @(negedge clock);
            if (d_ack) dcnt++;
            if (i_ack) icnt++;
            if (g_ack) gcyc = c;
        end
        checkOutput("starve_d_grants", 64'(dcnt), 8);
        checkOutput("starve_i_grants", 64'(icnt), 0);
        checkOutput("starve_g_ack_cycle", 64'(gcyc), 36);
        checkOutput("starve_g_rdata", rdata, 32'hDEAD_BEEF);
        first = 3'b000;
        for (int c = 0; c < 10 && first == 3'b000; c++) begin
            @(negedge clock);
            first = {d_ack, i_ack, g_ack};
        end
        checkOutput("starve_cleared_next_grant", first, 3'b100);
        applyStimulus(0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 16'h0);
        @(negedge clock);
        checkOutput("starve_idle", {busy, d_ack, i_ack, g_ack}, 0);

        // Reset in the middle of a read
        $display("[TB] reset mid-wait");
        @(negedge clock);
        applyStimulus(0, 0, 16'h0, 32'h0, 1, 16'h0010, 0, 16'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rstw_busy_en", {busy, mem_en, mem_we}, 0);
        checkOutput("rstw_acks", {d_ack, i_ack, g_ack}, 0);
        checkOutput("rstw_rdata", rdata, 0);
        checkOutput("rstw_addr", mem_addr, 0);
        @(negedge clock);
        checkOutput("rstw_held_busy", busy, 0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rstw_r1_en", mem_en, 1);
        checkOutput("rstw_r1_addr", mem_addr, 14'h0004);
        @(negedge clock);
        checkOutput("rstw_r2_acks", {d_ack, i_ack, g_ack}, 0);
        @(negedge clock);
        checkOutput("rstw_r3_acks", {d_ack, i_ack, g_ack}, 0);
        @(negedge clock);
        checkOutput("rstw_r4_acks", {d_ack, i_ack, g_ack}, 3'b010);
        checkOutput("rstw_r4_rdata", rdata, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 16'h0, 32'h0, 0, 16'h0, 0, 16'h0);

        // RD_LAT=3 instance
        $display("[TB] read latency 3");
        @(negedge clock);
        s_i_req  = 1'b1;
        s_i_addr = 16'h0018;
        #1;
        checkOutput("lat3_c0_stall", s_stall_if, 1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            checkOutput($sformatf("lat3_ack_c%0d", c), s_i_ack, (c == 6) ? 1'b1 : 1'b0);
            if (c == 1) begin
                checkOutput("lat3_c1_en_we", {s_mem_en, s_mem_we}, 2'b10);
                checkOutput("lat3_c1_addr", s_mem_addr, 14'h0006);
                checkOutput("lat3_c1_wdata", s_mem_wdata, 0);
            end
            if (c == 6) begin
                checkOutput("lat3_rdata", s_rdata, 32'h600D_F00D);
                checkOutput("lat3_other_acks", {s_d_ack, s_g_ack, s_busy, s_stall_mem}, 0);
                s_i_req = 1'b0;
            end
        end
        @(negedge clock);
        checkOutput("lat3_idle", {s_busy, s_i_ack}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous word RAM between three requesters: the MEM-stage data access, the IF-stage instruction fetch, and the UI debug reader.
- Serialises accesses with fixed priority (data > fetch > debug), plus a starvation guard for debug.
- Sequences each access through an issue/wait/done state machine.
- Drives the pipeline stall signals for IF and MEM while their requests are outstanding.

Parameters:
ADDR_W, 16, byte-address width of all requester address ports
DATA_W, 32, data word width
RD_LAT, 1, RAM read latency in clock edges after the issue edge (>=1)
STARVE_LIMIT, 8, lost arbitrations after which a pending debug request wins outright

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
d_req  in  1  data request, level, held until d_ack
d_we  in  1  data write enable, qualified by d_req
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  data write value
d_ack  out  1  one-cycle completion pulse for data
i_req  in  1  fetch request (read only), held until i_ack
i_addr  in  ADDR_W  fetch byte address
i_ack  out  1  one-cycle completion pulse for fetch
g_req  in  1  debug read request, held until g_ack
g_addr  in  ADDR_W  debug byte address
g_ack  out  1  one-cycle completion pulse for debug
rdata  out  DATA_W  read data, valid while any ack is high
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W-2  RAM word address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, RD_LAT edges after the issue edge
busy  out  1  state != IDLE
stall_if  out  1  i_req & ~i_ack (combinational)
stall_mem  out  1  d_req & ~d_ack (combinational)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all acks, mem_en, mem_we = 0; rdata, mem_addr, mem_wdata = 0; starve_cnt=0; wait counter=0.
  - A write in progress is aborted; RAM contents are then undefined for that address only.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Arbitrate on asserted reqs.
  - Normal order: d > i > g. Exception: if g_req=1 and starve_cnt==STARVE_LIMIT, g wins.
  - Winner id, word address (addr[ADDR_W-1:2]; addr[1:0] ignored), we (d_we for data, 0 otherwise) and wdata are latched; next state ISSUE.
  - No req: stay IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we=latched we; mem_addr and mem_wdata from latches.
  - Write: next state DONE. Read: next state WAIT, wait counter=RD_LAT-1.
- WAIT:
  - mem_en=0.
  - Counter nonzero: decrement.
  - Counter zero: capture mem_rdata into rdata; next state DONE.
- DONE (exactly 1 cycle):
  - Ack of the latched winner = 1; other acks = 0; next state IDLE.
  - For writes, rdata holds its previous value.
- Latency, first IDLE cycle to ack:
  - Write: 3 cycles.
  - Read: 3+RD_LAT cycles (4 with default).
  - A requester holding req drops it on the edge ending its ack cycle. A back-to-back request is sampled in the following IDLE cycle; no idle gap beyond IDLE is required.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each IDLE arbitration where g_req=1 and g loses.
  - Cleared when g is granted or g_req=0 in IDLE.
- Protocol violation: req dropped before ack. The transaction still completes and the ack still pulses. Any write is still performed.
- Simultaneous events:
  - A new req arriving while busy waits for IDLE.
  - Reqs present at the same IDLE cycle resolve by priority only.
- mem_en and mem_we are never high outside ISSUE.
- At most one ack is high in any cycle.

Test Plan:
- Reset then single fetch: i_req=1, i_addr=0x0010, mem_rdata=0xDEADBEEF one edge after issue → mem_addr=0x0004 in ISSUE; i_ack high in cycle 4; rdata=0xDEADBEEF; stall_if high in cycles 0–3.
- Data write: d_req=1, d_we=1, d_addr=0x0008, d_wdata=0x12345678 → ISSUE cycle shows mem_en=1, mem_we=1, mem_addr=0x0002, mem_wdata=0x12345678; d_ack in cycle 3; rdata unchanged.
- Contention: d_req, i_req, g_req asserted together, all held → grant order d, i, g; acks in cycles 3, 8, 13 (d write 3, then reads of 4 each plus IDLE); never two acks in the same cycle.
- Starvation guard: g_req held; d_req/i_req continuously re-requested → g granted at the 9th arbitration (after 8 losses); starve_cnt returns to 0.
- Reset mid-WAIT: drop reset during a read's WAIT → all outputs 0 immediately; no ack after release; state IDLE; pending reqs re-arbitrated on the first clock after release.
- RD_LAT=3 build: single read → ack in cycle 6; rdata equals mem_rdata presented 3 edges after the issue edge.
